// File: rtl/pipeline_issue_pkg.sv
// Shared types for the pipeline issue/flow-control sequencer.
package pipeline_issue_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2,
      ST_IDLE  = 2'd3
   } state_e;

   // One slot of the tag delay line that shadows the datapath.
   typedef struct packed {
      logic valid;
      logic last;
   } tag_t;

endpackage

// File: rtl/issue_fifo.sv
// Result buffer: synchronous FIFO with occupancy count and async active-low reset.
module issue_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign do_pop = pop_i && (count_q != '0);

   always_comb begin
      count_d = count_q;
      case ({push_i, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_d;
      end
   end

   // Storage carries no reset; the count alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Credits upstream must make a push into a full buffer unreachable.
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push_i && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/pipeline_issue_ctrl.sv
// Issue sequencer for a fixed-latency non-stallable datapath: credit-gated launch,
// tag tracking of in-flight beats, result buffering and a drain handshake.
module pipeline_issue_ctrl
   import pipeline_issue_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int LATENCY    = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  pipe_en,
   output logic [DATA_WIDTH-1:0] pipe_in_data,
   input  logic [DATA_WIDTH-1:0] pipe_out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   input  logic                  drain_req,
   output logic                  drain_done,
   output logic [CNT_WIDTH-1:0]  occupancy
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  last;
   } entry_t;

   state_e               state_q, state_d;
   tag_t                 tag_q [LATENCY];
   logic [CNT_WIDTH-1:0] in_flight_q, in_flight_d;
   logic [CNT_WIDTH-1:0] fifo_count;
   logic [CNT_WIDTH-1:0] credits;
   entry_t               wr_entry, rd_entry;
   logic                 launch, push, pop;

   // Every launched beat reserves a buffer slot, so a result always has room.
   assign credits  = CNT_WIDTH'(FIFO_DEPTH) - fifo_count - in_flight_q;
   assign in_ready = rst && (state_q == ST_RUN) && !drain_req && (credits != '0);
   assign launch   = in_valid && in_ready;

   assign pipe_en      = launch;
   assign pipe_in_data = in_data;

   assign push     = tag_q[LATENCY-1].valid;
   assign wr_entry = '{data: pipe_out_data, last: tag_q[LATENCY-1].last};

   assign out_valid  = (fifo_count != '0);
   assign pop        = out_valid && out_ready;
   assign out_data   = rd_entry.data;
   assign out_last   = rd_entry.last;
   assign occupancy  = fifo_count + in_flight_q;
   assign drain_done = (state_q == ST_DONE);

   always_comb begin
      in_flight_d = in_flight_q;
      case ({launch, push})
         2'b10:   in_flight_d = in_flight_q + CNT_WIDTH'(1);
         2'b01:   in_flight_d = in_flight_q - CNT_WIDTH'(1);
         default: in_flight_d = in_flight_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_flight_q <= '0;
         for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
      end else begin
         in_flight_q <= in_flight_d;
         tag_q[0]    <= '{valid: launch, last: in_last};
         for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_RUN;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:   if (drain_req) state_d = ST_DRAIN;
         ST_DRAIN: if ((in_flight_q == '0) && (fifo_count == '0)) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         ST_IDLE:  if (!drain_req) state_d = ST_RUN;
         default:  state_d = ST_RUN;
      endcase
   end

   issue_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_WIDTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .push_i  (push),
      .wdata_i (wr_entry),
      .pop_i   (pop),
      .rdata_o (rd_entry),
      .count_o (fifo_count)
   );

endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// Bench for pipeline_issue_ctrl: transaction-level scoreboard plus scenario tasks.
module tb_pipeline_issue_ctrl;

   localparam int DW    = 32;
   localparam int LAT   = 4;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          in_last = 1'b0;
   logic          pipe_en;
   logic [DW-1:0] pipe_in_data;
   logic [DW-1:0] pipe_out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          drain_req = 1'b0;
   logic          drain_done;
   logic [CW-1:0] occupancy;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      int            t;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   bit   drain_active = 1'b0;

   logic [DW-1:0] dp [LAT];

   pipeline_issue_ctrl #(
      .DATA_WIDTH (DW),
      .LATENCY    (LAT),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_last       (in_last),
      .pipe_en       (pipe_en),
      .pipe_in_data  (pipe_in_data),
      .pipe_out_data (pipe_out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_last      (out_last),
      .drain_req     (drain_req),
      .drain_done    (drain_done),
      .occupancy     (occupancy)
   );

   function automatic logic [DW-1:0] dp_func(input logic [DW-1:0] x);
      return x ^ 32'h3C5A_9601;
   endfunction

   initial forever #5 clk = ~clk;

   // Datapath stand-in: LAT register stages; idle slots carry junk.
   always @(posedge clk) begin
      dp[0] <= pipe_en ? dp_func(pipe_in_data) : $urandom;
      for (int i = 1; i < LAT; i++) dp[i] <= dp[i-1];
   end
   assign pipe_out_data = dp[LAT-1];

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Scoreboard: a beat launched at edge t is poppable from edge t+LAT until taken.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         exp_q.delete();
         n_vec++;
         if ({in_ready, out_valid, pipe_en} !== 3'b000 || occupancy !== '0) begin
            n_err++;
            $display("FAIL rst_outputs: rdy/ov/en=%b occ=%0d required 000/0",
                     {in_ready, out_valid, pipe_en}, occupancy);
         end
      end else begin
         n_vec++;
         if (out_valid !== (exp_q.size() > 0 && exp_q[0].t + LAT <= cyc)) begin
            n_err++;
            $display("FAIL sb_out_valid: cyc %0d got %b queued %0d", cyc, out_valid, exp_q.size());
         end
         n_vec++;
         if (occupancy !== CW'(exp_q.size())) begin
            n_err++;
            $display("FAIL sb_occupancy: cyc %0d got %0d required %0d", cyc, occupancy, exp_q.size());
         end
         n_vec++;
         if (pipe_en !== (in_valid && in_ready)) begin
            n_err++;
            $display("FAIL sb_pipe_en: cyc %0d got %b required %b", cyc, pipe_en, in_valid && in_ready);
         end
         if (!drain_active) begin
            n_vec++;
            if (in_ready !== (!drain_req && exp_q.size() < DEPTH)) begin
               n_err++;
               $display("FAIL sb_in_ready: cyc %0d got %b queued %0d", cyc, in_ready, exp_q.size());
            end
         end
         if (out_valid === 1'b1 && exp_q.size() > 0) begin
            n_vec++;
            if ({out_data, out_last} !== {exp_q[0].data, exp_q[0].last}) begin
               n_err++;
               $display("FAIL sb_data: cyc %0d got %h/%b required %h/%b", cyc,
                        out_data, out_last, exp_q[0].data, exp_q[0].last);
            end
            if (out_ready) void'(exp_q.pop_front());
         end
         if (in_valid && in_ready)
            exp_q.push_back('{data: dp_func(in_data), last: in_last, t: cyc + 1});
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, %0d miscompares so far", n_err);
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      in_valid = 1'b1;
      in_data  = $urandom;
      out_ready = 1'b1;
      repeat (3) tick();
      n_vec++;
      if ({in_ready, out_valid, pipe_en, drain_done} !== 4'b0000 || occupancy !== '0) begin
         n_err++;
         $display("FAIL reset_state: rdy/ov/en/dd=%b occ=%0d required 0000/0",
                  {in_ready, out_valid, pipe_en, drain_done}, occupancy);
      end
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_release_ready: got %b required 1", in_ready);
      end
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'h0000_00A5;
      in_last  = 1'b1;
      #1;
      n_vec++;
      if (pipe_en !== 1'b1) begin
         n_err++;
         $display("FAIL single_launch: pipe_en got %b required 1", pipe_en);
      end
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      for (int k = 1; k < LAT; k++) begin
         tick();
         n_vec++;
         if (out_valid !== 1'b0 || occupancy !== CW'(1)) begin
            n_err++;
            $display("FAIL single_inflight: k=%0d ov=%b occ=%0d required 0/1", k, out_valid, occupancy);
         end
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== dp_func(32'h0000_00A5) || out_last !== 1'b1) begin
         n_err++;
         $display("FAIL single_result: ov=%b data=%h last=%b required 1/%h/1",
                  out_valid, out_data, out_last, dp_func(32'h0000_00A5));
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b0 || occupancy !== '0) begin
         n_err++;
         $display("FAIL single_popped: ov=%b occ=%0d required 0/0", out_valid, occupancy);
      end
   endtask

   task automatic test_back_to_back();
      int drops = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 32; i++) begin
         in_valid = 1'b1;
         in_data  = DW'(i);
         in_last  = (i == 31);
         #1;
         if (in_ready !== 1'b1) drops++;
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      n_vec++;
      if (drops != 0) begin
         n_err++;
         $display("FAIL b2b_ready: in_ready low %0d times required 0", drops);
      end
      for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick();
      tick();
      n_vec++;
      if (exp_q.size() != 0 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_flush: %0d beats outstanding ov=%b required 0/0", exp_q.size(), out_valid);
      end
   endtask

   task automatic test_backpressure();
      int launches = 0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_data = $urandom;
         in_last = $urandom_range(0, 1);
         #1;
         if (in_ready === 1'b1) launches++;
         tick();
      end
      n_vec++;
      if (launches != DEPTH || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL bp_launches: got %0d rdy=%b required %0d/0", launches, in_ready, DEPTH);
      end
      n_vec++;
      if (occupancy !== CW'(DEPTH) || out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL bp_full: occ=%0d ov=%b required %0d/1", occupancy, out_valid, DEPTH);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_release_ready: got %b required 1", in_ready);
      end
      for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick();
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL bp_flush: %0d beats outstanding required 0", exp_q.size());
      end
   endtask

   task automatic test_random_push_pop();
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = $urandom;
         in_last   = $urandom_range(0, 1);
         out_ready = ((i % 2) == 0) ^ ($urandom_range(0, 4) == 0);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick();
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL rand_flush: %0d beats outstanding required 0", exp_q.size());
      end
   endtask

   task automatic test_drain();
      int pulses = 0;
      int early = 0;
      int rdy_hi = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = $urandom;
         in_last  = (i == 4);
         tick();
      end
      drain_active = 1'b1;
      drain_req = 1'b1;
      #1;
      n_vec++;
      if (in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL drain_first_cycle: in_ready got %b required 0", in_ready);
      end
      for (int k = 0; k < 40; k++) begin
         tick();
         if (in_ready !== 1'b0) rdy_hi++;
         if (drain_done === 1'b1) begin
            pulses++;
            if (exp_q.size() != 0) early++;
         end
      end
      n_vec++;
      if (pulses != 1 || early != 0 || rdy_hi != 0) begin
         n_err++;
         $display("FAIL drain_pulse: pulses=%0d early=%0d rdy_hi=%0d required 1/0/0", pulses, early, rdy_hi);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      drain_req = 1'b0;
      tick();
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL drain_resume: in_ready got %b required 1", in_ready);
      end
      drain_active = 1'b0;
   endtask

   task automatic test_drain_empty();
      drain_active = 1'b1;
      drain_req = 1'b1;
      tick();
      drain_req = 1'b0;
      n_vec++;
      if (drain_done !== 1'b0 || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL drain_empty_c1: dd=%b rdy=%b required 0/0", drain_done, in_ready);
      end
      tick();
      n_vec++;
      if (drain_done !== 1'b1) begin
         n_err++;
         $display("FAIL drain_empty_c2: dd=%b required 1", drain_done);
      end
      tick();
      n_vec++;
      if (drain_done !== 1'b0 || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL drain_empty_idle: dd=%b rdy=%b required 0/0", drain_done, in_ready);
      end
      tick();
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL drain_empty_run: rdy=%b required 1", in_ready);
      end
      drain_active = 1'b0;
   endtask

   task automatic test_reset_midflight();
      int stale = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = $urandom;
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || occupancy !== '0 || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL midreset_now: ov=%b occ=%0d rdy=%b required 0/0/0", out_valid, occupancy, in_ready);
      end
      tick();
      tick();
      rst = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (out_valid !== 1'b0) stale++;
      end
      n_vec++;
      if (stale != 0) begin
         n_err++;
         $display("FAIL midreset_stale: out_valid high %0d cycles required 0", stale);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_random_push_pop();
      test_drain();
      test_drain_empty();
      test_reset_midflight();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
